memory_stage: RTL and testbench
===============================

// Module: memory_stage
// PURPOSE
//  MEM stage of the 5-stage RV32I pipeline, directly downstream of the execute/EX-MEM block.
//  Consumes RD_M, ALU_ResultM, WriteDataM and PCPlus4M plus M-stage control.
//  Performs byte/half/word loads and stores on a local synchronous-write data RAM.
//  Registers the MEM/WB pipeline stage and drives ResultW/RDW/RegWriteW back to the register file and forwarding muxes.
// PARAMETERS
//  DEPTH_LOG2   10   log2 of data RAM depth in 32-bit words (1024 words = 4 KiB)
// PORTS
//  clk          in   1   pipeline clock, all state on rising edge
//  rst          in   1   asynchronous, active-low reset
//  RegWriteM    in   1   instruction in M writes the register file
//  MemWriteM    in   1   instruction in M is a store
//  ResultSrcM   in   2   00 ALU result, 01 load data, 10 PC+4, 11 ALU result
//  Funct3M      in   3   load/store width: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  RD_M         in   5   destination register in M
//  ALU_ResultM  in   32  byte address (ld/st) or ALU result
//  WriteDataM   in   32  store data (forwarded rs2)
//  PCPlus4M     in   32  PC+4 of instruction in M
//  MisalignM    out  1   combinational: current ld/st address misaligned for its width
//  RegWriteW    out  1   registered write enable to register file
//  RDW          out  5   registered destination register
//  ResultSrcW   out  2   registered result select
//  ALU_ResultW  out  32  registered ALU result
//  ReadDataW    out  32  registered, formatted load data
//  PCPlus4W     out  32  registered PC+4
//  ResultW      out  32  combinational WB mux of the W registers
// BEHAVIOUR
//  - RAM mem[0:2**DEPTH_LOG2-1] x 32, little-endian.
//    Word index = ALU_ResultM[DEPTH_LOG2+1:2]; upper address bits are ignored (address wraps modulo RAM size).
//  - Read: combinational in M. Lane select by addr[1:0].
//    * LB/LBU: sign/zero-extend the selected byte.
//    * LH/LHU: select half by addr[1], sign/zero-extend.
//    * LW: full word.
//    * Reserved funct3 (011/110/111): treated as LW.
//  - Write: on posedge clk when MemWriteM=1 && MisalignM=0. Byte enables:
//    * SB: 1 lane (addr[1:0]), data = WriteDataM[7:0] replicated.
//    * SH: 2 lanes (addr[1]), data = WriteDataM[15:0].
//    * SW: all lanes.
//    * Reserved funct3: no write.
//  - MisalignM = (ld or st) && ((H/HU && addr[0]) || (W && addr[1:0]!=0)).
//    "ld" means ResultSrcM==01; "st" means MemWriteM. Byte accesses are never misaligned.
//  - Misaligned store: RAM unchanged.
//    Misaligned load: ReadDataW<=0 and RegWriteW<=0 (no architectural write).
//  - MEM/WB register: one-cycle latency M->W. All W outputs update every posedge (no stall/flush inputs).
//    A bubble arrives as RegWriteM=0/MemWriteM=0.
//  - ResultW: ResultSrcW 00 -> ALU_ResultW, 01 -> ReadDataW, 10 -> PCPlus4W, 11 -> ALU_ResultW.
//  - Store then load to the same word in the next cycle: the load returns the new data (write lands at the edge between them).
//  - RDW=0 with RegWriteW=1 is passed through unchanged; x0 suppression belongs to the register file.
//  - Reset (rst=0, async):
//    * RegWriteW=0, RDW=0, ResultSrcW=00; ALU_ResultW, ReadDataW, PCPlus4W = 0; hence ResultW=0.
//    * RAM contents are NOT cleared.
//    * A store with rst low at the edge is not performed.
//    * Reset mid-operation discards the in-flight M instruction.
//  - Timing: RAM read must fit a single cycle (asynchronous-read array).
// TESTING
//  1. SW 0xDEADBEEF @0x10, next cycle LW @0x10 -> one cycle later ReadDataW=ResultW=0xDEADBEEF, RegWriteW=1.
//  2. SB 0x80 @0x05; LB @0x05 -> ReadDataW=0xFFFFFF80; LBU @0x05 -> 0x00000080;
//     LW @0x04 -> bytes 0,2,3 unchanged, byte 1 = 0x80.
//  3. SH 0x1234 @0x03 -> MisalignM=1, LW @0x00 unchanged.
//     LH @0x02 -> MisalignM=0, returns sign-extended RAM[0x02..0x03].
//  4. JAL-style ResultSrcM=10, PCPlus4M=0x104, RD_M=1 -> next cycle ResultW=0x104, RDW=1.
//  5. Store to addr 0x1000 + (1<<(DEPTH_LOG2+2)) -> aliases to 0x1000; LW @0x1000 returns the stored data.
//  6. Load in flight, pull rst low asynchronously between edges -> all W outputs 0 immediately;
//     after release, earlier-stored RAM data is still readable.

Source files
------------

// File: rtl/memory_stage.sv
// MEM stage of the 5-stage RV32I pipeline: byte/half/word access to a local data RAM
// (asynchronous read, synchronous write) followed by the MEM/WB pipeline register and WB mux.
module memory_stage #(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [2:0]  Funct3M,
  input  logic [4:0]  RD_M,
  input  logic [31:0] ALU_ResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCPlus4M,
  output logic        MisalignM,
  output logic        RegWriteW,
  output logic [4:0]  RDW,
  output logic [1:0]  ResultSrcW,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ResultW
);

  localparam int unsigned Words = 2 ** DEPTH_LOG2;

  logic [31:0]           mem [Words];
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [1:0]            off;
  logic                  is_ld;
  logic                  is_half;
  logic                  is_word;
  logic                  misalign_cond;
  logic                  ld_misalign;
  logic                  mem_we;
  logic [31:0]           rd_word;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [31:0]           ld_data;
  logic [31:0]           st_data;
  logic [3:0]            st_be;

  // Upper address bits are dropped, so accesses wrap modulo the RAM size.
  assign word_idx = ALU_ResultM[DEPTH_LOG2+1:2];
  assign off      = ALU_ResultM[1:0];
  assign is_ld    = (ResultSrcM == 2'b01);
  assign is_half  = (Funct3M[1:0] == 2'b01);
  // 010 plus the reserved 011/110/111 behave as word accesses.
  assign is_word  = Funct3M[1];

  assign misalign_cond = (is_half && off[0]) || (is_word && (off != 2'b00));
  assign MisalignM     = (is_ld || MemWriteM) && misalign_cond;
  assign ld_misalign   = is_ld && misalign_cond;
  assign mem_we        = MemWriteM && !MisalignM;

  assign rd_word = mem[word_idx];
  assign rd_byte = rd_word[{off, 3'b000} +: 8];
  assign rd_half = off[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    ld_data = rd_word;
    case (Funct3M)
      3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  ld_data = {24'h0, rd_byte};
      3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
      3'b101:  ld_data = {16'h0, rd_half};
      default: ld_data = rd_word;
    endcase
  end

  always_comb begin
    st_be   = 4'b0000;
    st_data = WriteDataM;
    case (Funct3M)
      3'b000: begin
        st_be   = 4'b0001 << off;
        st_data = {4{WriteDataM[7:0]}};
      end
      3'b001: begin
        st_be   = off[1] ? 4'b1100 : 4'b0011;
        st_data = {2{WriteDataM[15:0]}};
      end
      3'b010:  st_be = 4'b1111;
      default: st_be = 4'b0000;
    endcase
  end

  // RAM is never cleared; a store presented while reset is held is dropped.
  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) begin
          mem[word_idx][8*i +: 8] <= st_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteW   <= 1'b0;
      RDW         <= 5'd0;
      ResultSrcW  <= 2'b00;
      ALU_ResultW <= 32'h0;
      ReadDataW   <= 32'h0;
      PCPlus4W    <= 32'h0;
    end else begin
      RegWriteW   <= RegWriteM && !ld_misalign;
      RDW         <= RD_M;
      ResultSrcW  <= ResultSrcM;
      ALU_ResultW <= ALU_ResultM;
      ReadDataW   <= ld_misalign ? 32'h0 : ld_data;
      PCPlus4W    <= PCPlus4M;
    end
  end

  always_comb begin
    ResultW = ALU_ResultW;
    case (ResultSrcW)
      2'b01:   ResultW = ReadDataW;
      2'b10:   ResultW = PCPlus4W;
      default: ResultW = ALU_ResultW;
    endcase
  end

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed pipeline scenarios plus random traffic, all checked every
// cycle against a byte-level model of the RAM and the MEM/WB register.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic [4:0]  RD_M;
  logic [31:0] ALU_ResultM, WriteDataM, PCPlus4M;
  logic        MisalignM, RegWriteW;
  logic [4:0]  RDW;
  logic [1:0]  ResultSrcW;
  logic [31:0] ALU_ResultW, ReadDataW, PCPlus4W, ResultW;

  memory_stage #(.DEPTH_LOG2(10)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .Funct3M(Funct3M),
    .RD_M(RD_M), .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .MisalignM(MisalignM), .RegWriteW(RegWriteW), .RDW(RDW), .ResultSrcW(ResultSrcW),
    .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .ResultW(ResultW)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic        chk_en = 1'b1;
  logic        want_rst = 1'b0;
  logic        exp_mis = 1'b0, exp_rw = 1'b0;
  logic [4:0]  exp_rd = '0;
  logic [1:0]  exp_rs = '0;
  logic [31:0] exp_alu = '0, exp_rdata = '0, exp_pc = '0, exp_res = '0;

  logic [31:0] mdl [1024];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got %08h want %08h at %0t", name, got, want, $time);
    end
  endtask

  function automatic int unsigned acc_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic [31:0] load_fmt(input logic [31:0] w, input int unsigned o,
                                           input logic [2:0] f3);
    logic [31:0] sb, sh;
    logic [7:0]  b;
    logic [15:0] h;
    sb = w >> (8 * o);
    sh = w >> (8 * (o & 2));
    b  = sb[7:0];
    h  = sh[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  // Drive one M-stage instruction and predict what the W stage must hold after the edge.
  task automatic step(input logic rw, input logic mw, input logic [1:0] rs, input logic [2:0] f3,
                      input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] pc);
    int unsigned o, idx, sz;
    logic        ld, mis;
    logic [31:0] w;
    @(negedge clk);
    rst = want_rst;
    RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; Funct3M = f3;
    RD_M = rd; ALU_ResultM = addr; WriteDataM = wd; PCPlus4M = pc;
    o   = addr % 4;
    idx = (addr / 4) % 1024;
    sz  = acc_size(f3);
    ld  = (rs == 2'b01);
    mis = (ld || mw) && ((o % sz) != 0);
    exp_mis = mis;
    if (!rst) begin
      exp_rw = 1'b0; exp_rd = '0; exp_rs = '0;
      exp_alu = '0; exp_rdata = '0; exp_pc = '0; exp_res = '0;
    end else begin
      exp_rw    = rw && !(ld && mis);
      exp_rd    = rd;
      exp_rs    = rs;
      exp_alu   = addr;
      exp_pc    = pc;
      exp_rdata = (ld && mis) ? 32'h0 : load_fmt(mdl[idx], o, f3);
      exp_res   = (rs == 2'b01) ? exp_rdata : (rs == 2'b10) ? pc : addr;
      if (mw && !mis && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010)) begin
        w = mdl[idx];
        for (int k = 0; k < int'(sz); k++) w[8*(int'(o)+k) +: 8] = wd[8*k +: 8];
        mdl[idx] = w;
      end
    end
  endtask

  always begin
    @(negedge clk);
    #2;
    if (chk_en) check("MisalignM", 32'(MisalignM), 32'(exp_mis));
    @(posedge clk);
    #1;
    if (chk_en) begin
      check("RegWriteW", 32'(RegWriteW), 32'(exp_rw));
      check("RDW", 32'(RDW), 32'(exp_rd));
      check("ResultSrcW", 32'(ResultSrcW), 32'(exp_rs));
      check("ALU_ResultW", ALU_ResultW, exp_alu);
      check("PCPlus4W", PCPlus4W, exp_pc);
      if (!$isunknown(exp_rdata)) check("ReadDataW", ReadDataW, exp_rdata);
      if (!$isunknown(exp_res)) check("ResultW", ResultW, exp_res);
    end
  end

  task automatic post_check(input string name, input logic [31:0] got_sel,
                            input logic [31:0] want);
    check(name, got_sel, want);
  endtask

  initial begin
    logic [31:0] a;
    int          kind;
    RegWriteM = 0; MemWriteM = 0; ResultSrcM = 0; Funct3M = 0;
    RD_M = 0; ALU_ResultM = 0; WriteDataM = 0; PCPlus4M = 0;

    #3;
    check("reset RegWriteW", 32'(RegWriteW), 32'h0);
    check("reset ReadDataW", ReadDataW, 32'h0);
    check("reset ResultW", ResultW, 32'h0);

    step(0, 0, 2'b00, 3'b000, 0, 0, 0, 0);
    step(0, 0, 2'b00, 3'b000, 0, 0, 0, 0);
    want_rst = 1'b1;
    for (int i = 0; i < 16; i++) step(0, 1, 2'b00, 3'b010, 0, 4 * i, 32'h84210000 + i * 32'h1111, 0);

    // store then load of the same word on consecutive cycles
    step(0, 1, 2'b00, 3'b010, 0, 32'h10, 32'hDEADBEEF, 0);
    step(1, 0, 2'b01, 3'b010, 5, 32'h10, 0, 32'h40);
    @(posedge clk); #2;
    check("t1 ReadDataW", ReadDataW, 32'hDEADBEEF);
    check("t1 ResultW", ResultW, 32'hDEADBEEF);
    check("t1 RegWriteW", 32'(RegWriteW), 32'h1);

    step(0, 1, 2'b00, 3'b000, 0, 32'h05, 32'h12345680, 0);
    step(1, 0, 2'b01, 3'b000, 6, 32'h05, 0, 0);
    @(posedge clk); #2;
    check("t2 LB", ReadDataW, 32'hFFFFFF80);
    step(1, 0, 2'b01, 3'b100, 6, 32'h05, 0, 0);
    @(posedge clk); #2;
    check("t2 LBU", ReadDataW, 32'h00000080);
    step(1, 0, 2'b01, 3'b010, 6, 32'h04, 0, 0);
    @(posedge clk); #2;
    check("t2 LW", ReadDataW, 32'h84218011);

    step(0, 1, 2'b00, 3'b001, 0, 32'h03, 32'h1234, 0);
    #1 check("t3 SH misalign", 32'(MisalignM), 32'h1);
    step(1, 0, 2'b01, 3'b010, 9, 32'h00, 0, 0);
    @(posedge clk); #2;
    check("t3 LW unchanged", ReadDataW, 32'h84210000);
    step(1, 0, 2'b01, 3'b001, 9, 32'h02, 0, 0);
    #1 check("t3 LH aligned", 32'(MisalignM), 32'h0);
    @(posedge clk); #2;
    check("t3 LH", ReadDataW, 32'hFFFF8421);
    step(1, 0, 2'b01, 3'b010, 9, 32'h06, 0, 0);
    @(posedge clk); #2;
    check("misaligned LW RegWriteW", 32'(RegWriteW), 32'h0);
    check("misaligned LW ReadDataW", ReadDataW, 32'h0);

    step(1, 0, 2'b10, 3'b000, 1, 32'h0, 0, 32'h104);
    @(posedge clk); #2;
    check("t4 ResultW", ResultW, 32'h104);
    check("t4 RDW", 32'(RDW), 32'h1);

    step(0, 1, 2'b00, 3'b010, 0, 32'h2000, 32'hCAFEF00D, 0);
    step(1, 0, 2'b01, 3'b010, 3, 32'h1000, 0, 0);
    @(posedge clk); #2;
    check("t5 alias", ReadDataW, 32'hCAFEF00D);

    // asynchronous reset between edges while a load sits in W
    step(1, 0, 2'b01, 3'b010, 7, 32'h10, 0, 32'h88);
    @(posedge clk); #2;
    chk_en = 1'b0;
    rst = 1'b0;
    want_rst = 1'b0;
    #1;
    check("t6 RegWriteW", 32'(RegWriteW), 32'h0);
    check("t6 RDW", 32'(RDW), 32'h0);
    check("t6 ResultSrcW", 32'(ResultSrcW), 32'h0);
    check("t6 ALU_ResultW", ALU_ResultW, 32'h0);
    check("t6 ReadDataW", ReadDataW, 32'h0);
    check("t6 PCPlus4W", PCPlus4W, 32'h0);
    check("t6 ResultW", ResultW, 32'h0);
    chk_en = 1'b1;
    step(0, 1, 2'b00, 3'b010, 0, 32'h10, 32'h55555555, 0);
    want_rst = 1'b1;
    step(1, 0, 2'b01, 3'b010, 8, 32'h10, 0, 0);
    @(posedge clk); #2;
    check("t6 RAM kept", ReadDataW, 32'hDEADBEEF);

    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(0, 4);
      a    = $urandom & 32'hFFFF_F03F;
      case (kind)
        0: step(0, 1, 2'b00, 3'($urandom_range(0, 7)), 5'($urandom), a, $urandom, $urandom);
        1: step(1'($urandom_range(0, 3) != 0), 0, 2'b01, 3'($urandom_range(0, 7)),
                5'($urandom), a, $urandom, $urandom);
        2: step(1, 0, ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00, 3'($urandom_range(0, 7)),
                5'($urandom), a, $urandom, $urandom);
        3: step(1, 0, 2'b10, 3'($urandom_range(0, 7)), 5'($urandom), a, $urandom, $urandom);
        default: step(0, 0, 2'($urandom), 3'($urandom_range(0, 7)), 5'($urandom), a, $urandom,
                      $urandom);
      endcase
    end

    step(0, 0, 2'b00, 3'b000, 0, 0, 0, 0);
    @(posedge clk); #3;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
